// File: rtl/bus_arbiter.sv
// 4-master to 1-slave bus arbiter with latched slave request, timeout completion and core hold flag.
// Define BUS_ARB_ROUND_ROBIN_EN to replace fixed priority (M3 > M0 > M2 > M1) with round-robin arbitration.
module bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          m_req_i,
    input  logic [3:0]          m_we_i,
    input  logic [4*ADDR_W-1:0] m_addr_i,
    input  logic [4*DATA_W-1:0] m_wdata_i,
    output logic [DATA_W-1:0]   m_rdata_o,
    output logic [3:0]          m_ack_o,
    output logic [3:0]          m_err_o,
    output logic [3:0]          grant_o,
    output logic                s_req_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_addr_o,
    output logic [DATA_W-1:0]   s_wdata_o,
    input  logic [DATA_W-1:0]   s_rdata_i,
    input  logic                s_ack_i,
    output logic                hold_flag_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES + 2);
    localparam int TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    state_t           state, state_nxt;
    logic [3:0]       grant_q;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       win;
    logic             win_vld;
    logic             timeout;
    logic             done;

    assign win_vld = |m_req_i;

`ifdef BUS_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;

    // Scan offsets from high to low so the requester closest above rr_ptr is assigned last.
    always_comb begin
        win = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (m_req_i[rr_ptr + 2'(3 - i)]) win = rr_ptr + 2'(3 - i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          rr_ptr <= '0;
        else if (state == IDLE && win_vld) rr_ptr <= win + 2'd1;
    end
`else
    always_comb begin
        win = '0;
        if      (m_req_i[3]) win = 2'd3;
        else if (m_req_i[0]) win = 2'd0;
        else if (m_req_i[2]) win = 2'd2;
        else if (m_req_i[1]) win = 2'd1;
    end
`endif

    // A real slave ack in the final timeout cycle takes precedence over the error.
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TO_LAST)) && !s_ack_i;
    assign done    = (state == BUSY) && (s_ack_i || timeout);

    always_comb begin
        state_nxt = state;
        m_ack_o   = '0;
        m_err_o   = '0;
        m_rdata_o = '0;
        case (state)
            IDLE: if (win_vld) state_nxt = BUSY;
            BUSY: begin
                if (done) begin
                    state_nxt = IDLE;
                    m_ack_o   = grant_q;
                end
                if (s_ack_i) m_rdata_o = s_rdata_i;
                if (timeout) m_err_o   = grant_q;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign grant_o     = grant_q;
    assign hold_flag_o = |(m_req_i[1:0] & ~m_ack_o[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            grant_q   <= '0;
            s_req_o   <= 1'b0;
            s_we_o    <= 1'b0;
            s_addr_o  <= '0;
            s_wdata_o <= '0;
            cnt       <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (win_vld) begin
                    grant_q   <= 4'(1) << win;
                    s_req_o   <= 1'b1;
                    s_we_o    <= m_we_i[win];
                    s_addr_o  <= m_addr_i[win*ADDR_W +: ADDR_W];
                    s_wdata_o <= m_wdata_i[win*DATA_W +: DATA_W];
                    cnt       <= '0;
                end
                BUSY: begin
                    if (done) begin
                        grant_q   <= '0;
                        s_req_o   <= 1'b0;
                        s_we_o    <= 1'b0;
                        s_addr_o  <= '0;
                        s_wdata_o <= '0;
                        cnt       <= '0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Sequential 4-master to 1-slave arbiter for the core's shared memory/peripheral bus.
- Masters: M0 = core ex load/store, M1 = core instruction fetch, M2 = jtag debug, M3 = uart debug loader.
- Latches the winning request, holds it on the slave port until the slave acks or a timeout fires, then returns ack/data to the granted master only.
- Drives the core-pipeline hold flag whenever a core master (M0/M1) is waiting.

Parameters:
- ADDR_W, 32, address width per master.
- DATA_W, 32, data width.
- TIMEOUT_CYCLES, 255, BUSY cycles without s_ack_i before forced error completion; 0 disables timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- m_req_i  in  4  per-master request.
- m_we_i  in  4  per-master write enable.
- m_addr_i  in  4*ADDR_W  flattened addresses; master k at bits [k*ADDR_W +: ADDR_W].
- m_wdata_i  in  4*DATA_W  flattened write data, same packing.
- m_rdata_o  out  DATA_W  read data, shared; valid only with m_ack_o.
- m_ack_o  out  4  one-hot completion pulse.
- m_err_o  out  4  one-hot timeout-error pulse, coincident with m_ack_o.
- grant_o  out  4  one-hot current grant; 0 when idle.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  ADDR_W  slave address.
- s_wdata_o  out  DATA_W  slave write data.
- s_rdata_i  in  DATA_W  slave read data.
- s_ack_i  in  1  slave completion, 1 cycle.
- hold_flag_o  out  1  stall request to core ctrl.

Behaviour:
- Reset (rst=0, async): state IDLE; grant_o=0; s_req_o=0; s_we_o=0; s_addr_o=0; s_wdata_o=0; timeout counter=0; round-robin pointer=0. m_ack_o, m_err_o and m_rdata_o read 0.
- Reset asserted mid-transaction aborts it; no ack is issued.
- States: IDLE, BUSY.
- IDLE, any m_req_i set:
  - Winner selected combinationally by fixed priority M3 > M0 > M2 > M1.
  - On the clock edge: grant_o <= onehot(winner); s_req_o <= 1; s_we_o/s_addr_o/s_wdata_o <= winner's fields; counter <= 0; -> BUSY.
  - Latency: request at cycle N, s_req_o high at N+1.
- IDLE, no request: outputs hold idle values.
- BUSY: latched slave fields are stable; later changes on m_*_i are ignored. A master dropping m_req_i mid-transaction does not abort; it still receives ack.
- BUSY, s_ack_i=1:
  - Same cycle, combinational: m_ack_o[g]=1, m_rdata_o=s_rdata_i (also for writes).
  - Next edge: s_req_o <= 0, grant_o <= 0 -> IDLE.
  - There is always one IDLE arbitration cycle between transactions.
- BUSY, no ack: counter increments, saturating.
- Timeout (TIMEOUT_CYCLES != 0), counter == TIMEOUT_CYCLES-1 with no ack:
  - Same cycle: m_ack_o[g]=1, m_err_o[g]=1, m_rdata_o=0.
  - Next edge: -> IDLE, s_req_o <= 0.
  - If s_ack_i arrives in that same cycle, the normal ack wins and m_err_o stays 0.
- Master protocol: after ack, a master deasserts m_req_i or presents its next request; a still-high request in the IDLE cycle is treated as a new transaction.
- hold_flag_o = |(m_req_i[1:0] & ~m_ack_o[1:0]); purely combinational.
- m_ack_o and m_err_o are 0 in IDLE. Never more than one bit of m_ack_o is set.

Optional Feature:
- Macro: BUS_ARB_ROUND_ROBIN_EN.
- Defined:
  - IDLE arbitration searches upward from rr_ptr modulo 4; first requester wins.
  - rr_ptr <= (winner+1) mod 4 on each grant.
  - rr_ptr resets to 0.
- Undefined: fixed priority M3 > M0 > M2 > M1; rr_ptr logic is not present.

Test Plan:
- Single read: M0 req, addr 0x1000_0004; slave acks 3 cycles after s_req_o with 0xDEAD_BEEF -> s_req_o at N+1; m_ack_o=4'b0001 with m_rdata_o=0xDEAD_BEEF; hold_flag_o high until the ack cycle, low after.
- Contention: M1, M2, M3 request in the same cycle, fixed priority, 1-cycle slave -> grant order M3, M2, M1, one IDLE cycle between each.
- Timeout: TIMEOUT_CYCLES=4, M2 writes 0x55 to 0x2000_0000, slave never acks -> on the 4th BUSY cycle m_ack_o=m_err_o=4'b0100, m_rdata_o=0; IDLE next cycle.
- Stability: M0 changes m_addr_i and drops m_req_i during BUSY -> s_addr_o keeps the original address; M0 still receives ack.
- Async reset: rst low in BUSY mid-cycle -> s_req_o and grant_o go 0 immediately; no ack pulse; after release, a new M1 request is served normally.
- With BUS_ARB_ROUND_ROBIN_EN: all four masters requesting continuously -> grant order M0, M1, M2, M3, M0 (rr_ptr from 0).
